// File: rtl/enigma_rotor_stack.sv
// Multi-rotor Enigma engine: odometer-stepped rotors, fixed half-turn reflector,
// one-hot valid/ready stream in and a single registered output stage.
module enigma_rotor_stack #(
  parameter int unsigned NUM_ROTORS = 3,
  parameter int unsigned NOTCH      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [5*NUM_ROTORS-1:0] load_pos_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [25:0]             in_char_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [25:0]             out_char_o,
  output logic                    out_err_o,
  output logic [5*NUM_ROTORS-1:0] pos_o
);

  localparam logic [4:0] NotchPos = 5'(NOTCH);

  logic [NUM_ROTORS-1:0][4:0] pos_q, pos_d, pos_step;
  logic                       out_valid_q, out_valid_d;
  logic [25:0]                out_char_q, out_char_d;
  logic                       out_err_q, out_err_d;
  logic                       accept, one_hot, carry;
  logic [4:0]                 idx, x, lp;

  function automatic logic [4:0] mod_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] mod_sub(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + 6'd26 - {1'b0, b};
    return s[4:0];
  endfunction

  // Rotor wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ.
  function automatic logic [4:0] wire_fwd(input logic [4:0] i);
    case (i)
      5'd0:  return 5'd4;   5'd1:  return 5'd10;  5'd2:  return 5'd12;  5'd3:  return 5'd5;
      5'd4:  return 5'd11;  5'd5:  return 5'd6;   5'd6:  return 5'd3;   5'd7:  return 5'd16;
      5'd8:  return 5'd21;  5'd9:  return 5'd25;  5'd10: return 5'd13;  5'd11: return 5'd19;
      5'd12: return 5'd14;  5'd13: return 5'd22;  5'd14: return 5'd24;  5'd15: return 5'd7;
      5'd16: return 5'd23;  5'd17: return 5'd20;  5'd18: return 5'd18;  5'd19: return 5'd15;
      5'd20: return 5'd0;   5'd21: return 5'd8;   5'd22: return 5'd1;   5'd23: return 5'd17;
      5'd24: return 5'd2;   5'd25: return 5'd9;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] wire_bwd(input logic [4:0] i);
    case (i)
      5'd0:  return 5'd20;  5'd1:  return 5'd22;  5'd2:  return 5'd24;  5'd3:  return 5'd6;
      5'd4:  return 5'd0;   5'd5:  return 5'd3;   5'd6:  return 5'd5;   5'd7:  return 5'd15;
      5'd8:  return 5'd21;  5'd9:  return 5'd25;  5'd10: return 5'd1;   5'd11: return 5'd4;
      5'd12: return 5'd2;   5'd13: return 5'd10;  5'd14: return 5'd12;  5'd15: return 5'd19;
      5'd16: return 5'd7;   5'd17: return 5'd23;  5'd18: return 5'd18;  5'd19: return 5'd11;
      5'd20: return 5'd17;  5'd21: return 5'd8;   5'd22: return 5'd13;  5'd23: return 5'd16;
      5'd24: return 5'd14;  5'd25: return 5'd9;
      default: return 5'd0;
    endcase
  endfunction

  assign in_ready_o = !load_i && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign one_hot    = (in_char_i != '0) && ((in_char_i & (in_char_i - 26'd1)) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 26; i++) begin
      if (in_char_i[i]) idx = 5'(i);
    end
  end

  // Carry ripples from the fast rotor using pre-step positions only.
  always_comb begin
    carry = 1'b1;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      pos_step[k] = pos_q[k];
      if (carry) pos_step[k] = (pos_q[k] == 5'd25) ? 5'd0 : pos_q[k] + 5'd1;
      carry = carry && (pos_q[k] == NotchPos);
    end
  end

  always_comb begin
    x = idx;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      x = mod_sub(wire_fwd(mod_add(x, pos_step[k])), pos_step[k]);
    end
    x = mod_add(x, 5'd13);
    for (int k = NUM_ROTORS - 1; k >= 0; k--) begin
      x = mod_sub(wire_bwd(mod_add(x, pos_step[k])), pos_step[k]);
    end
  end

  always_comb begin
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_err_d   = out_err_q;
    lp          = '0;
    if (load_i) begin
      for (int k = 0; k < NUM_ROTORS; k++) begin
        lp       = load_pos_i[5*k +: 5];
        pos_d[k] = (lp >= 5'd26) ? lp - 5'd26 : lp;
      end
    end else if (accept && one_hot) begin
      pos_d = pos_step;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_char_d  = one_hot ? (26'd1 << x) : '0;
      out_err_d   = !one_hot;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_err_q   <= out_err_d;
    end
  end

  assign pos_o       = pos_q;
  assign out_valid_o = out_valid_q;
  assign out_char_o  = out_char_q;
  assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Directed bench: one- and three-rotor engines share stimulus; expected letters
// and positions are worked out by hand from the rotor wiring.
module tb_enigma_rotor_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [4:0]  load_pos1 = '0;
  logic [14:0] load_pos3 = '0;
  logic        in_valid = 1'b0;
  logic [25:0] in_char = '0;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1, out_err1;
  logic [25:0] out_char1;
  logic [4:0]  pos1;
  logic        in_ready3, out_valid3, out_err3;
  logic [25:0] out_char3;
  logic [14:0] pos3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  enigma_rotor_stack #(.NUM_ROTORS(1), .NOTCH(16)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load), .load_pos_i(load_pos1),
    .in_valid_i(in_valid), .in_ready_o(in_ready1), .in_char_i(in_char),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_char_o(out_char1),
    .out_err_o(out_err1), .pos_o(pos1)
  );

  enigma_rotor_stack #(.NUM_ROTORS(3), .NOTCH(16)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load), .load_pos_i(load_pos3),
    .in_valid_i(in_valid), .in_ready_o(in_ready3), .in_char_i(in_char),
    .out_valid_o(out_valid3), .out_ready_i(out_ready), .out_char_o(out_char3),
    .out_err_o(out_err3), .pos_o(pos3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [4:0] p1, input logic [14:0] p3);
    load      = 1'b1;
    load_pos1 = p1;
    load_pos3 = p3;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at a negedge; returns at the next negedge with the result registered.
  task automatic send(input logic [25:0] c);
    in_valid  = 1'b1;
    in_char   = c;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [25:0] e1;
  int          p, c;

  initial begin
    // Reset state
    do_reset();
    check("rst_pos1", 32'(pos1), 32'd0);
    check("rst_pos3", 32'(pos3), 32'd0);
    check("rst_valid", 32'(out_valid1), 32'd0);
    check("rst_char", 32'(out_char1), 32'd0);
    check("rst_err", 32'(out_err3), 32'd0);
    check("rst_ready", 32'(in_ready1), 32'd1);

    // 'A' from zero positions: N=1 gives 'P', N=3 gives 'D'
    send(26'd1);
    check("a_valid", 32'(out_valid1), 32'd1);
    check("a_n1_char", 32'(out_char1), 32'(26'd1 << 15));
    check("a_n1_pos", 32'(pos1), 32'd1);
    check("a_n3_char", 32'(out_char3), 32'(26'd1 << 3));
    check("a_n3_pos", 32'(pos3), 32'd1);

    do_reset();
    send(26'd1 << 15);
    check("p_n1_char", 32'(out_char1), 32'd1);

    // Reciprocity and no fixed point at random positions
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(0, 25);
      c = $urandom_range(0, 25);
      do_load(5'(p), '0);
      send(26'd1 << c);
      e1 = out_char1;
      check("recip_onehot", 32'($countones(e1)), 32'd1);
      check("recip_nofix", 32'(e1 != (26'd1 << c)), 32'd1);
      do_load(5'(p), '0);
      send(e1);
      check("recip_back", 32'(out_char1), 32'(26'd1 << c));
    end

    // Odometer carries through the notch
    do_load(5'd0, {5'd0, 5'd0, 5'd16});
    send(26'd1);
    check("carry1", 32'(pos3), 32'({5'd0, 5'd1, 5'd17}));
    do_load(5'd0, {5'd0, 5'd16, 5'd16});
    send(26'd1);
    check("carry2", 32'(pos3), 32'({5'd1, 5'd17, 5'd17}));

    // Wrap 25->0 and load modulo 26; load blocks accept
    do_load(5'd25, '0);
    send(26'd1);
    check("wrap_pos", 32'(pos1), 32'd0);
    check("wrap_char", 32'(out_char1), 32'(26'd1 << 23));
    load      = 1'b1;
    load_pos1 = 5'd30;
    in_valid  = 1'b1;
    in_char   = 26'd1;
    #1;
    check("load_noready", 32'(in_ready1), 32'd0);
    @(negedge clk);
    load     = 1'b0;
    in_valid = 1'b0;
    check("load30_pos", 32'(pos1), 32'd4);
    check("load_noacc", 32'(out_valid1), 32'd0);

    // Backpressure then full-throughput stream
    do_reset();
    send(26'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_char   = 26'd1 << 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(in_ready1), 32'd0);
      check("bp_char", 32'(out_char1), 32'(26'd1 << 15));
      check("bp_pos", 32'(pos1), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("st_b_char", 32'(out_char1), 32'(26'd1 << 16));
    check("st_b_pos", 32'(pos1), 32'd2);
    in_char = 26'd1 << 2;
    @(negedge clk);
    check("st_c_char", 32'(out_char1), 32'(26'd1 << 8));
    check("st_c_pos", 32'(pos1), 32'd3);
    in_valid = 1'b0;
    @(negedge clk);
    check("st_drain", 32'(out_valid1), 32'd0);

    // Invalid character: flagged, no step
    send(26'h3);
    check("bad_err", 32'(out_err1), 32'd1);
    check("bad_char", 32'(out_char1), 32'd0);
    check("bad_valid", 32'(out_valid1), 32'd1);
    check("bad_pos", 32'(pos1), 32'd3);
    send(26'd0);
    check("zero_err", 32'(out_err3), 32'd1);

    // Asynchronous reset mid-stream
    send(26'd1);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid1), 32'd0);
    check("arst_pos1", 32'(pos1), 32'd0);
    check("arst_pos3", 32'(pos3), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
